// File: rtl/peecc_uart_pkg.sv
// Shared UART definitions for the PEECC serial path: default line settings,
// receive FSM states and bit-timing helper. UART_RX_PARITY_EN adds the PARITY state.
`timescale 1ns/1ps
package peecc_uart_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 48000000;
  localparam int DEFAULT_BAUD        = 57600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

  // Full bit period (half_bit=0) or half bit period (half_bit=1), in clocks, truncated.
  function automatic int bit_clks(input int clk_freq_hz, input int baud, input bit half_bit);
    int cpb;
    cpb = clk_freq_hz / baud;
    return half_bit ? cpb / 2 : cpb;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: 2-FF line synchroniser, start-edge detect and mid-bit sampling FSM.
// 8N1 by default; defining UART_RX_PARITY_EN makes it 8E1 with a PARITY state.
`timescale 1ns/1ps
module uart_rx_byte
  import peecc_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD        = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CLKS_PER_BIT = bit_clks(CLK_FREQ_HZ, BAUD, 1'b0);
  localparam int HALF_BIT     = bit_clks(CLK_FREQ_HZ, BAUD, 1'b1);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  logic            rx_p0, rx_s, rx_p2;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            bit_done, half_done, stop_ok;

  // Line synchroniser; the third flop only feeds the falling-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
      rx_p2 <= rx_s;
    end
  end

  assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_done = (cnt_q == CNT_W'(HALF_BIT - 1));

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign stop_ok = rx_s & ~par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_p2 && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is already high again at mid-bit was a glitch
        if (half_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_err_d = rx_s ^ (^shreg_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed
        if (bit_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (stop_ok) byte_valid = 1'b1;
          else         byte_err   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/uart_word_rx.sv
// UART receive stage for the PEECC encoder: packs WORD_BYTES bytes little-endian
// into a word behind a valid/ready holding register. UART_RX_PARITY_EN selects 8E1.
`timescale 1ns/1ps
module uart_word_rx
  import peecc_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD        = DEFAULT_BAUD,
  parameter int WORD_BYTES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_err,
  output logic                    overrun_err
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [7:0]              byte_data;
  logic                    byte_valid, byte_err;
  logic [IDX_W-1:0]        byte_idx;
  logic [8*WORD_BYTES-1:0] asm_q, asm_d;
  logic                    word_done, word_load;

  uart_rx_byte #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_idx, 3'b000} +: 8] = byte_data;
  end

  assign word_done = byte_valid && (byte_idx == IDX_W'(WORD_BYTES - 1));
  // A finished word may replace the held one only if it leaves this same cycle
  assign word_load = word_done && (!word_valid || word_ready);

  always_ff @(posedge clk) begin
    if (byte_valid) asm_q <= asm_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx    <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= byte_err;
      overrun_err <= word_done && !word_load;
      if (byte_err)
        byte_idx <= '0;
      else if (byte_valid)
        byte_idx <= word_done ? '0 : byte_idx + 1'b1;
      if (word_load) begin
        word_data  <= asm_d;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx (8N1 build) run at 115200 baud to keep runtime short.
`timescale 1ns/1ps
module tb_uart_word_rx;
  import peecc_uart_pkg::*;

  localparam int CLK_FREQ_HZ = 48000000;
  localparam int BAUD        = 115200;
  localparam int WORD_BYTES  = 2;
  localparam int CPB         = CLK_FREQ_HZ / BAUD;   // 416
  localparam int HALF        = CPB / 2;              // 208
  localparam int LAT         = 3 + HALF + 9 * CPB;   // start edge to word_valid high

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic [15:0] word_data;
  logic        word_valid, frame_err, overrun_err;

  uart_word_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .WORD_BYTES  (WORD_BYTES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #10.417 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, bv_cnt = 0, wv_cnt = 0;
  int rise_cyc = 0;
  int last_start = 0;
  logic [15:0] xfer_data = '0;
  logic wv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (overrun_err) ov_cnt <= ov_cnt + 1;
    if (word_valid)  wv_cnt <= wv_cnt + 1;
    if (dut.u_rx.byte_valid) bv_cnt <= bv_cnt + 1;
    if (word_valid && word_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      xfer_data <= word_data;
    end
    if (word_valid && !wv_prev) rise_cyc <= cyc;
    wv_prev <= word_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  int fe0, ov0, xf0, bv0, wv0;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    wait_clks(5);
    check("rst_word_data", word_data, 16'h0000);
    check("rst_word_valid", word_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
    rst_n = 1'b1;
    wait_clks(CPB);

    // All-zero word with the consumer always ready
    word_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; xf0 = xfer_cnt; wv0 = wv_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_clks(CPB);
    check("zero_xfer_count", xfer_cnt - xf0, 1);
    check("zero_word_data", xfer_data, 16'h0000);
    check("zero_valid_width", wv_cnt - wv0, 1);
    check("zero_latency", rise_cyc - last_start, LAT);
    check("zero_no_frame_err", fe_cnt - fe0, 0);
    check("zero_no_overrun", ov_cnt - ov0, 0);
    check("zero_valid_dropped", word_valid, 1'b0);

    // Byte ordering, back-to-back frames
    xf0 = xfer_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_clks(CPB);
    check("order_xfer_count", xfer_cnt - xf0, 1);
    check("order_word_data", xfer_data, 16'h3CA5);

    // Glitch shorter than half a bit
    fe0 = fe_cnt; bv0 = bv_cnt;
    rx = 1'b0;
    wait_clks(200);
    rx = 1'b1;
    wait_clks(2 * CPB);
    check("glitch_no_byte", bv_cnt - bv0, 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    check("glitch_fsm_idle", dut.u_rx.state_q, ST_IDLE);

    // Framing error then recovery
    fe0 = fe_cnt; xf0 = xfer_cnt;
    send_byte(8'h55, 1'b0);
    rx = 1'b1;
    wait_clks(CPB);
    check("ferr_pulse_once", fe_cnt - fe0, 1);
    check("ferr_no_word", xfer_cnt - xf0, 0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_clks(CPB);
    check("ferr_recover_count", xfer_cnt - xf0, 1);
    check("ferr_recover_data", xfer_data, 16'h3412);

    // Overrun while the consumer stalls
    word_ready = 1'b0;
    ov0 = ov_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clks(4);
    check("ovr_valid_held", word_valid, 1'b1);
    check("ovr_data_held", word_data, 16'h2211);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_clks(4);
    check("ovr_pulse_once", ov_cnt - ov0, 1);
    check("ovr_data_kept", word_data, 16'h2211);
    check("ovr_valid_kept", word_valid, 1'b1);
    word_ready = 1'b1;
    check("ovr_xfer_data", word_data, 16'h2211);
    wait_clks(1);
    check("ovr_valid_cleared", word_valid, 1'b0);

    // Reset during data bit 4 of the second byte of a word
    fe0 = fe_cnt;
    send_byte(8'hAB, 1'b1);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    wait_clks(HALF);
    rst_n = 1'b0;
    wait_clks(3);
    check("mid_rst_word_data", word_data, 16'h0000);
    check("mid_rst_word_valid", word_valid, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    check("mid_rst_overrun_err", overrun_err, 1'b0);
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * CPB);
    xf0 = xfer_cnt;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_clks(CPB);
    check("mid_rst_xfer_count", xfer_cnt - xf0, 1);
    check("mid_rst_word", xfer_data, 16'h01FF);
    check("mid_rst_no_frame_err", fe_cnt - fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
